mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle MIPS-style control unit. A Mealy FSM walks each instruction
//   through FETCH / DECODE / EXEC / MEM / WB / ALUWB and, when exceptions are
//   enabled, through single-cycle EXC_OF / EXC_UD / EXC_BUS states.
//
//   Build option: define MCFSM_EXCEPTION_EN to enable the exception states,
//   the bus-timeout wait counter, and the EPCWrite/CauseWrite/IntCause outputs.
//   With the macro undefined, undefined opcodes retire straight back to FETCH,
//   overflow is ignored, and memory waits are unbounded.
//
// Parameters
//   TO_LIMIT     max MemReady-low wait cycles before a bus timeout
//
// Ports
//   CLK          clock, rising edge
//   reset        synchronous active-high reset
//   Op[5:0]      opcode field of IR
//   MemReady     memory completes the current access this cycle
//   overflow     ALU signed overflow of the current operation
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegWrite, RegDst, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], FuncType,
//   PCSource[1:0], ReverseZflag, EPCWrite, CauseWrite, IntCause[1:0]
//                datapath control outputs
//   dbg_state    current FSM state encoding, for observation only
//
// Outputs are decoded combinationally from the state register because
// several of them (IRWrite/PCWrite in FETCH, RegWrite in ALUWB, the reset
// write-gating) must react to inputs within the same cycle.
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int TO_LIMIT = 15
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    input  logic       overflow,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       FuncType,
    output logic [1:0] PCSource,
    output logic       ReverseZflag,
    output logic       EPCWrite,
    output logic       CauseWrite,
    output logic [1:0] IntCause,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
`ifdef MCFSM_EXCEPTION_EN
        S_ALUWB  = 4'd5,
        S_EXC_OF = 4'd6,
        S_EXC_UD = 4'd7,
        S_EXC_BUS = 4'd8
`else
        S_ALUWB  = 4'd5
`endif
    } state_t;

    state_t state_q, state_d;

    // Opcode classes
    logic is_r, is_j, is_beq, is_bne, is_lw, is_sw, is_imm, op_defined;
    assign is_r   = (Op == 6'b000000);
    assign is_j   = (Op == 6'b000010);
    assign is_beq = (Op == 6'b000100);
    assign is_bne = (Op == 6'b000101);
    assign is_lw  = (Op == 6'b100011);
    assign is_sw  = (Op == 6'b101011);
    assign is_imm = (Op[5:3] == 3'b001);
    assign op_defined = is_r | is_j | is_beq | is_bne | is_lw | is_sw | is_imm;

    // at_limit: this is the last permitted wait cycle and memory is still
    // not ready, so the access is abandoned in favour of EXC_BUS.
    logic at_limit;
    logic waiting;
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MemReady;

`ifdef MCFSM_EXCEPTION_EN
    localparam int CW = (TO_LIMIT < 1) ? 1 : $clog2(TO_LIMIT + 1);
    logic [CW-1:0] wait_q;
    assign at_limit = waiting && (wait_q == CW'(TO_LIMIT));
`else
    assign at_limit = 1'b0;
    logic unused_ovf;
    assign unused_ovf = overflow;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
`ifdef MCFSM_EXCEPTION_EN
                end else if (at_limit) begin
                    state_d = S_EXC_BUS;
`endif
                end
            end
            S_DECODE: begin
                if (op_defined) begin
                    state_d = S_EXEC;
                end else begin
`ifdef MCFSM_EXCEPTION_EN
                    state_d = S_EXC_UD;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_r || is_imm) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (MemReady) begin
                    state_d = is_lw ? S_WB : S_FETCH;
`ifdef MCFSM_EXCEPTION_EN
                end else if (at_limit) begin
                    state_d = S_EXC_BUS;
`endif
                end
            end
            S_WB: state_d = S_FETCH;
            S_ALUWB: begin
`ifdef MCFSM_EXCEPTION_EN
                state_d = overflow ? S_EXC_OF : S_FETCH;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register and wait counter. The counter clears whenever the
    // state changes, so every wait episode starts counting from zero.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_FETCH;
`ifdef MCFSM_EXCEPTION_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MCFSM_EXCEPTION_EN
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (waiting) begin
                wait_q <= wait_q + 1'b1;
            end
`endif
        end
    end

    // Output decode
    logic pc_write_raw, pc_write_cond_raw, ir_write_raw, mem_write_raw;
    logic reg_write_raw, epc_write_raw, cause_write_raw;

    always_comb begin
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        ir_write_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        reg_write_raw     = 1'b0;
        epc_write_raw     = 1'b0;
        cause_write_raw   = 1'b0;
        IorD              = 1'b0;
        MemRead           = 1'b0;
        MemtoReg          = 1'b0;
        RegDst            = 1'b0;
        ALUSrcA           = 1'b0;
        ALUSrcB           = 2'b00;
        ALUOp             = 2'b00;
        FuncType          = 1'b0;
        PCSource          = 2'b00;
        ReverseZflag      = 1'b0;
        IntCause          = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    ALUSrcB      = 2'b01;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end else if (is_r) begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end else if (is_imm) begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    ALUOp    = 2'b10;
                    FuncType = 1'b1;
                end else if (is_beq || is_bne) begin
                    ALUSrcA           = 1'b1;
                    ALUOp             = 2'b01;
                    pc_write_cond_raw = 1'b1;
                    PCSource          = 2'b01;
                    ReverseZflag      = Op[0];
                end else if (is_j) begin
                    pc_write_raw = 1'b1;
                    PCSource     = 2'b10;
                end
            end
            S_MEM: begin
                IorD          = 1'b1;
                MemRead       = is_lw;
                mem_write_raw = is_sw && !at_limit;
            end
            S_WB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_ALUWB: begin
                RegDst = is_r;
`ifdef MCFSM_EXCEPTION_EN
                reg_write_raw = !overflow;
`else
                reg_write_raw = 1'b1;
`endif
            end
`ifdef MCFSM_EXCEPTION_EN
            S_EXC_OF, S_EXC_UD, S_EXC_BUS: begin
                epc_write_raw   = 1'b1;
                cause_write_raw = 1'b1;
                ALUSrcB         = 2'b01;
                ALUOp           = 2'b01;
                pc_write_raw    = 1'b1;
                PCSource        = 2'b11;
                if (state_q == S_EXC_OF) begin
                    IntCause = 2'b01;
                end else if (state_q == S_EXC_BUS) begin
                    IntCause = 2'b10;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Architectural write enables are suppressed for the whole reset cycle.
    assign PCWrite     = pc_write_raw      & ~reset;
    assign PCWriteCond = pc_write_cond_raw & ~reset;
    assign IRWrite     = ir_write_raw      & ~reset;
    assign MemWrite    = mem_write_raw     & ~reset;
    assign RegWrite    = reg_write_raw     & ~reset;
    assign EPCWrite    = epc_write_raw     & ~reset;
    assign CauseWrite  = cause_write_raw   & ~reset;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Instruction-level bench: each instruction is expanded into the list of
//   cycles it should take, with the control word expected in each cycle,
//   and the DUT outputs are compared cycle by cycle. Inputs are driven 1 ns
//   after the rising edge and outputs sampled 2 ns later.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int TO = 15;

    logic       CLK;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       overflow;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource, IntCause;
    logic       FuncType, ReverseZflag, EPCWrite, CauseWrite;
    logic [3:0] dbg_state;

    mc_control_fsm #(.TO_LIMIT(TO)) dut (
        .CLK(CLK), .reset(reset), .Op(Op), .MemReady(MemReady), .overflow(overflow),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .FuncType(FuncType), .PCSource(PCSource), .ReverseZflag(ReverseZflag),
        .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .IntCause(IntCause),
        .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       func_type;
        logic [1:0] pc_source;
        logic       rev_z;
        logic       epc_write;
        logic       cause_write;
        logic [1:0] int_cause;
    } ctl_t;

    ctl_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, FuncType, PCSource,
                  ReverseZflag, EPCWrite, CauseWrite, IntCause};

    typedef enum int {C_R, C_J, C_BEQ, C_BNE, C_LW, C_SW, C_IMM, C_UD} op_class_t;

    int checks = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic op_class_t op_class(input logic [5:0] op);
        casez (op)
            6'b000000: return C_R;
            6'b000010: return C_J;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b001???: return C_IMM;
            default:   return C_UD;
        endcase
    endfunction

    function automatic ctl_t v_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_read = 1'b1;
        if (rdy) begin
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
        end
        return c;
    endfunction

    function automatic ctl_t v_decode();
        ctl_t c = '0;
        c.alu_src_b = 2'b11;
        return c;
    endfunction

    function automatic ctl_t v_exec(input op_class_t cls);
        ctl_t c = '0;
        case (cls)
            C_LW, C_SW: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            C_R:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            C_IMM: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; c.func_type = 1; end
            C_BEQ, C_BNE: begin
                c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.rev_z = (cls == C_BNE);
            end
            C_J:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            default: begin end
        endcase
        return c;
    endfunction

    function automatic ctl_t v_mem(input logic lw, input logic limit);
        ctl_t c = '0;
        c.iord      = 1'b1;
        c.mem_read  = lw;
        c.mem_write = !lw && !limit;
        return c;
    endfunction

    function automatic ctl_t v_wb();
        ctl_t c = '0;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t v_aluwb(input logic is_r, input logic rw);
        ctl_t c = '0;
        c.reg_dst   = is_r;
        c.reg_write = rw;
        return c;
    endfunction

    function automatic ctl_t v_exc(input logic [1:0] cause);
        ctl_t c = '0;
        c.epc_write   = 1'b1;
        c.cause_write = 1'b1;
        c.int_cause   = cause;
        c.alu_src_b   = 2'b01;
        c.alu_op      = 2'b01;
        c.pc_write    = 1'b1;
        c.pc_source   = 2'b11;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of inputs, compares the control word, then advances
    // to 1 ns past the next rising edge.
    task automatic step(input logic rdy, input logic ovf, input ctl_t exp_raw, input string name);
        ctl_t e;
        e = exp_raw;
        if (reset) begin
            e.pc_write = 0; e.pc_write_cond = 0; e.ir_write = 0; e.mem_write = 0;
            e.reg_write = 0; e.epc_write = 0; e.cause_write = 0;
        end
        MemReady = rdy;
        overflow = ovf;
        #2;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL %s: op=%b got=%h expected=%h", name, Op, obs, e);
        end
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction starting from FETCH.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic ovf);
        op_class_t cls;
        logic ovf_exc;
        cls = op_class(op);
        Op = op;
        for (int i = 0; i < fw; i++) begin
            step(1'b0, rbit(), v_fetch(1'b0), "fetch_wait");
`ifdef MCFSM_EXCEPTION_EN
            if (i == TO) begin
                step(rbit(), rbit(), v_exc(2'b10), "exc_bus_fetch");
                return;
            end
`endif
        end
        step(1'b1, rbit(), v_fetch(1'b1), "fetch");
        step(rbit(), rbit(), v_decode(), "decode");
        if (cls == C_UD) begin
`ifdef MCFSM_EXCEPTION_EN
            step(rbit(), rbit(), v_exc(2'b00), "exc_ud");
`endif
            return;
        end
        step(rbit(), rbit(), v_exec(cls), "exec");
        if (cls == C_LW || cls == C_SW) begin
            for (int i = 0; i < mw; i++) begin
`ifdef MCFSM_EXCEPTION_EN
                step(1'b0, rbit(), v_mem(cls == C_LW, i == TO), "mem_wait");
                if (i == TO) begin
                    step(rbit(), rbit(), v_exc(2'b10), "exc_bus_mem");
                    return;
                end
`else
                step(1'b0, rbit(), v_mem(cls == C_LW, 1'b0), "mem_wait");
`endif
            end
            step(1'b1, rbit(), v_mem(cls == C_LW, 1'b0), "mem");
            if (cls == C_LW) step(rbit(), rbit(), v_wb(), "wb");
        end else if (cls == C_R || cls == C_IMM) begin
`ifdef MCFSM_EXCEPTION_EN
            ovf_exc = ovf;
`else
            ovf_exc = 1'b0;
`endif
            step(rbit(), ovf, v_aluwb(cls == C_R, !ovf_exc), "aluwb");
            if (ovf_exc) step(rbit(), rbit(), v_exc(2'b01), "exc_of");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        Op = 6'b000000;
        step(1'b1, 1'b0, v_fetch(1'b1), "reset_fetch_gated");
        step(1'b0, 1'b0, v_fetch(1'b0), "reset_fetch_idle");
        reset = 1'b0;
    endtask

    task automatic test_add();
        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b000000, 2, 0, 1'b0);
    endtask

    task automatic test_mem_ops();
        run_instr(6'b100011, 0, 3, 1'b0);
        run_instr(6'b101011, 1, 0, 1'b0);
        run_instr(6'b101011, 0, 2, 1'b0);
    endtask

    task automatic test_branch_jump();
        run_instr(6'b000101, 0, 0, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
    endtask

    task automatic test_imm();
        run_instr(6'b001000, 0, 0, 1'b0);
        run_instr(6'b001101, 0, 0, 1'b1);
    endtask

    task automatic test_undefined();
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b000001, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_mem();
        Op = 6'b101011;
        step(1'b1, 1'b0, v_fetch(1'b1), "rmm_fetch");
        step(1'b0, 1'b0, v_decode(), "rmm_decode");
        step(1'b0, 1'b0, v_exec(C_SW), "rmm_exec");
        reset = 1'b1;
        step(1'b0, 1'b0, v_mem(1'b0, 1'b0), "reset_mid_mem");
        reset = 1'b0;
        run_instr(6'b000000, 0, 0, 1'b0);
    endtask

`ifdef MCFSM_EXCEPTION_EN
    task automatic test_timeout();
        run_instr(6'b000000, TO + 5, 0, 1'b0);   // stuck in FETCH
        run_instr(6'b000000, TO, 0, 1'b0);       // ready in the limit cycle wins
        run_instr(6'b101011, 0, TO + 3, 1'b0);   // stuck in MEM, write suppressed
        run_instr(6'b100011, 0, TO, 1'b0);
    endtask

    task automatic test_reset_mid_exc();
        Op = 6'b111111;
        step(1'b1, 1'b0, v_fetch(1'b1), "rme_fetch");
        step(1'b0, 1'b0, v_decode(), "rme_decode");
        reset = 1'b1;
        step(1'b0, 1'b0, v_exc(2'b00), "reset_mid_exc");
        reset = 1'b0;
        run_instr(6'b000010, 0, 0, 1'b0);
    endtask
`else
    task automatic test_unbounded_wait();
        run_instr(6'b100011, 30, 30, 1'b0);
        run_instr(6'b101011, 0, 25, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b000000;
                1: op = 6'b000010;
                2: op = 6'b000100;
                3: op = 6'b000101;
                4: op = 6'b100011;
                5: op = 6'b101011;
                6: op = {3'b001, 3'($urandom_range(0, 7))};
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op_class(op) != C_UD) op = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rbit());
        end
    endtask

    // ---------------- main ----------------
    initial begin
        reset = 1'b1;
        Op = 6'b000000;
        MemReady = 1'b0;
        overflow = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_add();
        test_mem_ops();
        test_branch_jump();
        test_imm();
        test_undefined();
        test_reset_mid_mem();
`ifdef MCFSM_EXCEPTION_EN
        test_timeout();
        test_reset_mid_exc();
`else
        test_unbounded_wait();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
